// File: rtl/note_pkg.sv
// Shared constants for the note front-end and the tone player.
package note_pkg;

  localparam int NUM_NOTES = 7;
  localparam int NOTE_DO   = 0;
  localparam int NOTE_RE   = 1;
  localparam int NOTE_MI   = 2;
  localparam int NOTE_FA   = 3;
  localparam int NOTE_SOL  = 4;
  localparam int NOTE_LA   = 5;
  localparam int NOTE_SI   = 6;

  // Seven note keys plus the play/stop key, which sits on the top bit.
  localparam int NUM_INPUTS = NUM_NOTES + 1;
  localparam int PLAY_IDX   = NUM_NOTES;

  localparam int DEFAULT_DB_CYCLES = 250000;
  localparam int CLK_HZ            = 25000000;

  // Keep only the lowest set bit, so "do" wins over every other key.
  function automatic logic [NUM_NOTES-1:0] lowest_onehot(input logic [NUM_NOTES-1:0] v);
    return v & (~v + NUM_NOTES'(1));
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a saturating-free debounce counter.
// The stable output only follows the input after DB_CYCLES consecutive
// cycles of disagreement; any return to agreement restarts the count.
module debounce_bit
  import note_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatches; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/note_input_ctrl.sv
// Front end for the tone player: debounces the seven note keys and the
// play/stop key, picks the highest-priority held note and toggles the
// play enable on each debounced press of play/stop.
module note_input_ctrl
  import note_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_NOTES-1:0] btn,
  input  logic                 play_btn,
  output logic [NUM_NOTES-1:0] note,
  output logic                 onoff,
  output logic                 note_valid,
  output logic                 note_chg
);

  logic [NUM_INPUTS-1:0] raw_s;
  logic [NUM_INPUTS-1:0] stable_s;

  logic [NUM_NOTES-1:0]  note_q;
  logic [NUM_NOTES-1:0]  note_d;
  logic                  note_valid_q;
  logic                  note_valid_d;
  logic                  note_chg_q;
  logic                  note_chg_d;
  logic                  onoff_q;
  logic                  onoff_d;
  logic                  play_prev_q;
  logic                  play_prev_d;
  logic                  play_rise_s;

  assign raw_s = {play_btn, btn};

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_db
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_s[gi]),
      .stable_o(stable_s[gi])
    );
  end

  // Next-state for note select, change strobe and play toggle.
  always_comb begin
    note_d       = lowest_onehot(stable_s[NUM_NOTES-1:0]);
    note_valid_d = |note_d;
    note_chg_d   = (note_d != note_q);
    play_rise_s  = stable_s[PLAY_IDX] & ~play_prev_q;
    play_prev_d  = stable_s[PLAY_IDX];
    if (play_rise_s) begin
      onoff_d = ~onoff_q;
    end else begin
      onoff_d = onoff_q;
    end
  end

  // Output and edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q       <= '0;
      note_valid_q <= 1'b0;
      note_chg_q   <= 1'b0;
      onoff_q      <= 1'b0;
      play_prev_q  <= 1'b0;
    end else begin
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      note_chg_q   <= note_chg_d;
      onoff_q      <= onoff_d;
      play_prev_q  <= play_prev_d;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign note_chg   = note_chg_q;
  assign onoff      = onoff_q;

endmodule

// File: tb/tb_note_input_ctrl.sv
// Bench for note_input_ctrl: table of held-key patterns, hand sequences for
// bounce / priority / play / async reset, randomized keys against a window
// model, and a long-pulse test on a second instance with a larger debounce.
module tb_note_input_ctrl;

  localparam int DB  = 4;
  localparam int DBL = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn, btn_l;
  logic       play_btn, play_l;
  logic [6:0] note, note_l;
  logic       onoff, onoff_l, note_valid, note_valid_l, note_chg, note_chg_l;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  note_input_ctrl #(.DB_CYCLES(DB)) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .play_btn(play_btn),
    .note(note), .onoff(onoff), .note_valid(note_valid), .note_chg(note_chg)
  );

  note_input_ctrl #(.DB_CYCLES(DBL)) u_long (
    .clk(clk), .rst(rst), .btn(btn_l), .play_btn(play_l),
    .note(note_l), .onoff(onoff_l), .note_valid(note_valid_l), .note_chg(note_chg_l)
  );

  // Reference model: history of raw samples, one per clock edge.
  logic [7:0] rh[$];
  logic [7:0] ms_prev, ms_prev2;
  logic [6:0] note_m;
  logic       chg_m, onoff_m;

  typedef struct {
    logic [6:0] keys;
    logic [6:0] exp_note;
    logic       exp_valid;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [6:0] lowest(input logic [6:0] s);
    logic [6:0] r;
    logic       found;
    r = 7'd0;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (s[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    rh.delete();
    ms_prev  = 8'd0;
    ms_prev2 = 8'd0;
    note_m   = 7'd0;
    chg_m    = 1'b0;
    onoff_m  = 1'b0;
  endtask

  // A key's stable level flips when the DB samples seen by the debouncer
  // (raw delayed by two edges) all differ from the current stable level.
  task automatic model_edge(input logic [7:0] r);
    logic [7:0] ms_new;
    logic [6:0] nn;
    logic       all_mis, v;
    int         idx;
    rh.push_back(r);
    while (rh.size() > DB + 3) void'(rh.pop_front());
    ms_new = ms_prev;
    for (int i = 0; i < 8; i++) begin
      all_mis = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        idx = rh.size() - 1 - j;
        v   = (idx >= 0) ? rh[idx][i] : 1'b0;
        if (v == ms_prev[i]) all_mis = 1'b0;
      end
      if (all_mis) ms_new[i] = ~ms_prev[i];
    end
    nn       = lowest(ms_prev[6:0]);
    chg_m    = (nn != note_m);
    note_m   = nn;
    onoff_m  = onoff_m ^ (ms_prev[7] & ~ms_prev2[7]);
    ms_prev2 = ms_prev;
    ms_prev  = ms_new;
  endtask

  task automatic step(input logic [6:0] b, input logic p);
    btn      = b;
    play_btn = p;
    @(posedge clk);
    model_edge({p, b});
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int pulses, changes, bad;
    logic prev_on;
    logic [6:0] rk;
    logic rp;
    int dur;

    btn = 7'd0; play_btn = 1'b0; btn_l = 7'd0; play_l = 1'b0; rst = 1'b1;
    model_reset();
    do_reset();
    chk("reset_outputs", {note, note_valid, note_chg, onoff}, 16'd0);
    chk("reset_outputs_long", {note_l, note_valid_l, note_chg_l, onoff_l}, 16'd0);

    // Clean press of fa: output 7 cycles after the edge, single strobe.
    for (int k = 1; k <= 20; k++) begin
      step(7'b0001000, 1'b0);
      if (k == 6) chk("press_early", {9'd0, note}, 16'd0);
      if (k == 7) chk("press_note", {note, note_valid, note_chg}, {7'd0, 7'b0001000, 1'b1, 1'b1});
      if (k == 8) chk("press_chg_once", {15'd0, note_chg}, 16'd0);
    end
    repeat (10) step(7'd0, 1'b0);
    chk("release_note", {note, note_valid}, 16'd0);

    // Bouncing re: three short high segments, then a clean hold.
    bad = 0;
    for (int s = 0; s < 2; s++) begin
      repeat (3) begin step(7'b0000010, 1'b0); if (note != 7'd0 || note_chg) bad++; end
      repeat (2) begin step(7'b0000000, 1'b0); if (note != 7'd0 || note_chg) bad++; end
    end
    repeat (3) begin step(7'b0000010, 1'b0); if (note != 7'd0 || note_chg) bad++; end
    repeat (2) begin step(7'b0000000, 1'b0); if (note != 7'd0 || note_chg) bad++; end
    for (int k = 1; k <= 12; k++) begin
      step(7'b0000010, 1'b0);
      if (k <= 6 && note != 7'd0) bad++;
      if (k == 7) chk("bounce_note", {note, note_chg}, {8'd0, 7'b0000010, 1'b1});
    end
    chk("bounce_quiet", bad[15:0], 16'd0);
    repeat (10) step(7'd0, 1'b0);

    // mi and la together, then release one at a time.
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(7'b0100100, 1'b0);
      pulses += note_chg;
      if (k == 7) chk("dual_note", {9'd0, note}, {9'd0, 7'b0000100});
    end
    chk("dual_pulses", pulses[15:0], 16'd1);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(7'b0100000, 1'b0);
      pulses += note_chg;
      if (k == 7) chk("rel_mi_note", {9'd0, note}, {9'd0, 7'b0100000});
    end
    chk("rel_mi_pulses", pulses[15:0], 16'd1);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step(7'b0000000, 1'b0);
      pulses += note_chg;
      if (k == 7) chk("rel_la_note", {note, note_valid, note_chg}, {7'd0, 7'd0, 1'b0, 1'b1});
    end
    chk("rel_la_pulses", pulses[15:0], 16'd1);

    // Lower-priority key added under a held do: no strobe.
    repeat (10) step(7'b0000001, 1'b0);
    pulses = 0;
    repeat (10) begin step(7'b0001001, 1'b0); pulses += note_chg; end
    chk("low_prio_no_chg", {pulses[8:0], note}, {9'd0, 7'b0000001});
    repeat (10) step(7'd0, 1'b0);

    // Play/stop: one toggle per press, nothing on release.
    changes = 0; prev_on = onoff;
    for (int k = 1; k <= 30; k++) begin
      step(7'd0, 1'b1);
      if (onoff != prev_on) changes++;
      prev_on = onoff;
      if (k == 6) chk("play_early", {15'd0, onoff}, 16'd0);
      if (k == 7) chk("play_on", {15'd0, onoff}, 16'd1);
    end
    chk("play_hold_one_toggle", changes[15:0], 16'd1);
    changes = 0;
    repeat (15) begin step(7'd0, 1'b0); if (onoff != prev_on) changes++; prev_on = onoff; end
    chk("play_release_none", {changes[14:0], onoff}, 16'd1);
    for (int k = 1; k <= 10; k++) begin
      step(7'd0, 1'b1);
      if (k == 7) chk("play_off", {15'd0, onoff}, 16'd0);
    end
    repeat (10) step(7'd0, 1'b0);

    // Asynchronous reset in the middle of a debounce.
    repeat (10) step(7'b1000000, 1'b1);
    chk("pre_rst_state", {8'd0, note, onoff}, {8'd0, 7'b1000000, 1'b1});
    repeat (3) step(7'b0010000, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst_clear", {note, note_valid, note_chg, onoff}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 10; k++) begin
      step(7'b0010000, 1'b0);
      if (k == 6) chk("post_rst_early", {9'd0, note}, 16'd0);
      if (k == 7) chk("post_rst_note", {9'd0, note}, {9'd0, 7'b0010000});
    end

    // Table of held patterns, each settled for DB+4 cycles.
    tv[0] = '{7'b0010000, 7'b0010000, 1'b1};
    tv[1] = '{7'b1100000, 7'b0100000, 1'b1};
    tv[2] = '{7'b1111111, 7'b0000001, 1'b1};
    tv[3] = '{7'b0000000, 7'b0000000, 1'b0};
    tv[4] = '{7'b1000000, 7'b1000000, 1'b1};
    tv[5] = '{7'b0001100, 7'b0000100, 1'b1};
    tv[6] = '{7'b0101010, 7'b0000010, 1'b1};
    tv[7] = '{7'b0000000, 7'b0000000, 1'b0};
    for (int t = 0; t < 8; t++) begin
      repeat (DB + 4) step(tv[t].keys, 1'b0);
      chk($sformatf("table_%0d", t), {note, note_valid, note_chg},
          {7'd0, tv[t].exp_note, tv[t].exp_valid, 1'b0});
    end

    // Randomized keys with random hold lengths, checked every cycle.
    bad = 0;
    for (int s = 0; s < 400; s++) begin
      rk  = 7'($urandom);
      if ($urandom_range(0, 2) == 0) rk = rk & 7'($urandom);
      rp  = ($urandom_range(0, 3) == 0);
      dur = $urandom_range(1, 9);
      repeat (dur) begin
        step(rk, rp);
        n_total++;
        if ({note, note_valid, note_chg, onoff} === {note_m, |note_m, chg_m, onoff_m}) n_pass++;
        else if (bad++ < 10)
          $display("FAIL random_model: got %h/%b/%b/%b want %h/%b/%b/%b",
                   note, note_valid, note_chg, onoff, note_m, |note_m, chg_m, onoff_m);
      end
    end
    repeat (10) step(7'd0, 1'b0);

    // Larger debounce: a pulse just short of the window is ignored.
    bad = 0;
    btn_l = 7'b0000001;
    repeat (DBL - 4) begin step(7'd0, 1'b0); if (note_l != 7'd0) bad++; end
    btn_l = 7'd0;
    repeat (DBL + 10) begin step(7'd0, 1'b0); if (note_l != 7'd0) bad++; end
    chk("long_short_pulse", bad[15:0], 16'd0);
    btn_l = 7'b0000001;
    for (int k = 1; k <= DBL + 40; k++) begin
      step(7'd0, 1'b0);
      if (k == DBL + 2) chk("long_early", {9'd0, note_l}, 16'd0);
      if (k == DBL + 3) chk("long_note", {note_l, note_valid_l, note_chg_l}, {7'd0, 7'b0000001, 1'b1, 1'b1});
    end
    btn_l = 7'd0;
    chk("long_held", {9'd0, note_l}, {9'd0, 7'b0000001});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
